match_controller: RTL

- Referee and score FSM for the two-player soccer game.
- Sits upstream of both player movement blocks and the ball block.
- Watches ball position and size each frame; detects goals at the left and right field edges; keeps scores.
- Drives the shared centerPlayer recentre pulse, a freeze level for the kickoff/celebration pause, and game-over status to the HUD/colour mapper.

---
 rtl/match_pkg.sv | 33 +++
 rtl/pause_timer.sv | 27 ++
 rtl/match_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared types and default field geometry for the soccer match referee.
package match_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RECENTER,
      PLAY,
      GOAL_PAUSE,
      GAME_OVER
   } match_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam int DEF_GOAL_TOP     = 190;
   localparam int DEF_GOAL_BOTTOM  = 290;
   localparam int DEF_LEFT_LINE    = 8;
   localparam int DEF_RIGHT_LINE   = 631;
   localparam int DEF_PAUSE_FRAMES = 120;
   localparam int DEF_WIN_SCORE    = 5;

   // Higher score wins; equal scores are a draw.
   function automatic logic [1:0] winner_of(input logic [3:0] p1, input logic [3:0] p2);
      if (p1 > p2)
         return WIN_P1;
      else if (p2 > p1)
         return WIN_P2;
      return WIN_DRAW;
   endfunction

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter that stops at zero; used for frame-count pauses.
module pause_timer #(
   parameter int WIDTH = 7
) (
   input  logic             frame_clk,
   input  logic             Reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] count_in,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)
         count <= '0;
      else if (load)
         count <= count_in;
      else if (enable && (count != '0))
         count <= count - WIDTH'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/match_controller.sv
// Referee/score FSM for the two-player soccer game.
// Define MATCH_TIMER_EN to add the match clock (MATCH_SECONDS, time_left).
module match_controller
   import match_pkg::*;
#(
   parameter int GOAL_TOP     = DEF_GOAL_TOP,
   parameter int GOAL_BOTTOM  = DEF_GOAL_BOTTOM,
   parameter int LEFT_LINE    = DEF_LEFT_LINE,
   parameter int RIGHT_LINE   = DEF_RIGHT_LINE,
   parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES,
   parameter int WIN_SCORE    = DEF_WIN_SCORE
`ifdef MATCH_TIMER_EN
   , parameter int MATCH_SECONDS = 90
`endif
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       start,
   input  logic [9:0] ballX,
   input  logic [9:0] ballY,
   input  logic [9:0] ballS,
   output logic       centerPlayer,
   output logic       freeze,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       goal_flash,
   output logic [1:0] winner,
   output logic       game_over
`ifdef MATCH_TIMER_EN
   , output logic [6:0] time_left
`endif
);

   localparam int PW = $clog2(PAUSE_FRAMES + 1);
   localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_FRAMES - 1);
   localparam logic [9:0]    TOP_Y      = 10'(GOAL_TOP);
   localparam logic [9:0]    BOT_Y      = 10'(GOAL_BOTTOM);
   localparam logic [10:0]   LEFT_X     = 11'(LEFT_LINE);
   localparam logic [10:0]   RIGHT_X    = 11'(RIGHT_LINE);
   localparam logic [3:0]    WIN_S      = 4'(WIN_SCORE);

   match_state_t state, next_state;
   logic start_q;
   logic in_mouth, left_goal, right_goal;
   logic pause_load, pause_zero;
   logic inc_p1, inc_p2, clear_match, end_match;

   // 11-bit sums keep ball edges near 1023 from wrapping.
   assign in_mouth   = (ballY >= TOP_Y) && (ballY <= BOT_Y);
   assign left_goal  = in_mouth && ({1'b0, ballX} <= LEFT_X + {1'b0, ballS});
   assign right_goal = in_mouth && ({1'b0, ballX} + {1'b0, ballS} >= RIGHT_X);

   pause_timer #(.WIDTH(PW)) u_goal_pause (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (pause_load),
      .enable    (state == GOAL_PAUSE),
      .count_in  (PAUSE_LOAD),
      .zero      (pause_zero)
   );

`ifdef MATCH_TIMER_EN
   logic sec_zero, sec_tick, timer_reload;

   // The clock restarts only for a fresh match, not after each goal.
   assign timer_reload = ((state == IDLE) && start) || clear_match;
   assign sec_tick     = (state == PLAY) && sec_zero;

   pause_timer #(.WIDTH(6)) u_sec_prescale (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (timer_reload || sec_tick),
      .enable    (state == PLAY),
      .count_in  (6'd59),
      .zero      (sec_zero)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)
         time_left <= 7'(MATCH_SECONDS);
      else if (timer_reload)
         time_left <= 7'(MATCH_SECONDS);
      else if (sec_tick && (time_left != 7'd0))
         time_left <= time_left - 7'd1;
   end
`endif

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         score_p1 <= 4'd0;
         score_p2 <= 4'd0;
         winner   <= WIN_NONE;
      end else begin
         state   <= next_state;
         start_q <= start;
         if (clear_match) begin
            score_p1 <= 4'd0;
            score_p2 <= 4'd0;
            winner   <= WIN_NONE;
         end else begin
            if (inc_p1 && (score_p1 < WIN_S))
               score_p1 <= score_p1 + 4'd1;
            if (inc_p2 && (score_p2 < WIN_S))
               score_p2 <= score_p2 + 4'd1;
            if (end_match)
               winner <= winner_of(score_p1, score_p2);
         end
      end
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      next_state   = state;
      centerPlayer = 1'b0;
      freeze       = 1'b1;
      goal_flash   = 1'b0;
      game_over    = 1'b0;
      pause_load   = 1'b0;
      inc_p1       = 1'b0;
      inc_p2       = 1'b0;
      clear_match  = 1'b0;
      end_match    = 1'b0;
      case (state)
         IDLE: begin
            centerPlayer = 1'b1;
            if (start)
               next_state = RECENTER;
         end
         RECENTER: begin
            centerPlayer = 1'b1;
            next_state   = PLAY;
         end
         PLAY: begin
            freeze = 1'b0;
            if (left_goal) begin
               inc_p2     = 1'b1;
               pause_load = 1'b1;
               next_state = GOAL_PAUSE;
            end else if (right_goal) begin
               inc_p1     = 1'b1;
               pause_load = 1'b1;
               next_state = GOAL_PAUSE;
            end
`ifdef MATCH_TIMER_EN
            else if (time_left == 7'd0) begin
               end_match  = 1'b1;
               next_state = GAME_OVER;
            end
`endif
         end
         GOAL_PAUSE: begin
            goal_flash = 1'b1;
            if (pause_zero) begin
               if ((score_p1 == WIN_S) || (score_p2 == WIN_S)) begin
                  end_match  = 1'b1;
                  next_state = GAME_OVER;
               end else begin
                  next_state = RECENTER;
               end
            end
         end
         GAME_OVER: begin
            game_over = 1'b1;
            // Only a fresh press restarts; a key held since the final goal does not.
            if (start && !start_q) begin
               clear_match = 1'b1;
               next_state  = RECENTER;
            end
         end
         default: next_state = IDLE;
      endcase
   end

endmodule
